// File: rtl/diffusion_stage_if.sv
// diffusion_stage_if: input/output stream bundle for the Ascon p_L stage
interface diffusion_stage_if #(parameter int CNT_W = 4);
  logic [4:0][63:0] state_i;
  logic             valid_i;
  logic             ready_o;
  logic [4:0][63:0] state_o;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] round_cnt_o;
  logic             last_o;
  logic             clear_i;
  modport slave (input state_i, valid_i, ready_i, clear_i,
                 output ready_o, state_o, valid_o, round_cnt_o, last_o);
  modport master (output state_i, valid_i, ready_i, clear_i,
                  input ready_o, state_o, valid_o, round_cnt_o, last_o);
endinterface

// File: rtl/diffusion_stage.sv
// diffusion_stage: registered Ascon linear layer with 2-entry skid buffer and round tagging
module diffusion_stage #(
  parameter int ROUNDS = 12,
  parameter int CNT_W  = 4
) (
  input logic clock_i,
  input logic resetb_i,
  diffusion_stage_if.slave s
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
  buf_t state_q, state_d;
  logic [4:0][63:0] m_q, m_d, s_q, s_d, diff;
  logic [CNT_W-1:0] mt_q, mt_d, st_q, st_d, cnt_q, cnt_d, tag_in;
  logic ready, valid, in_xfer, out_xfer;
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  assign ready         = state_q != FULL;
  assign valid         = state_q != EMPTY;
  assign in_xfer       = s.valid_i && ready;
  assign out_xfer      = valid && s.ready_i;
  assign s.ready_o     = ready;
  assign s.valid_o     = valid;
  assign s.state_o     = m_q;
  assign s.round_cnt_o = mt_q;
  assign s.last_o      = valid && (mt_q == LAST);
  assign tag_in        = s.clear_i ? '0 : cnt_q;
  assign cnt_d         = in_xfer ? ((tag_in == LAST) ? '0 : tag_in + CNT_W'(1))
                                 : (s.clear_i ? '0 : cnt_q);
  // row-wise XOR-rotate diffusion applied before the data is stored
  always_comb begin
    diff[0] = s.state_i[0] ^ rotr(s.state_i[0], 19) ^ rotr(s.state_i[0], 28);
    diff[1] = s.state_i[1] ^ rotr(s.state_i[1], 61) ^ rotr(s.state_i[1], 39);
    diff[2] = s.state_i[2] ^ rotr(s.state_i[2], 1)  ^ rotr(s.state_i[2], 6);
    diff[3] = s.state_i[3] ^ rotr(s.state_i[3], 10) ^ rotr(s.state_i[3], 17);
    diff[4] = s.state_i[4] ^ rotr(s.state_i[4], 7)  ^ rotr(s.state_i[4], 41);
  end
  // skid-buffer occupancy and data/tag movement between M and S
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    mt_d    = mt_q;
    s_d     = s_q;
    st_d    = st_q;
    case (state_q)
      EMPTY: if (in_xfer) begin
        state_d = ONE;
        m_d     = diff;
        mt_d    = tag_in;
      end
      ONE: if (in_xfer && out_xfer) begin
        m_d  = diff;
        mt_d = tag_in;
      end else if (in_xfer) begin
        state_d = FULL;
        s_d     = diff;
        st_d    = tag_in;
      end else if (out_xfer) begin
        state_d = EMPTY;
      end
      FULL: if (out_xfer) begin
        state_d = ONE;
        m_d     = s_q;
        mt_d    = st_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state, data and round counter registers; reset discards buffered beats
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q <= EMPTY;
      m_q     <= '0;
      mt_q    <= '0;
      s_q     <= '0;
      st_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      mt_q    <= mt_d;
      s_q     <= s_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
